// File: rtl/memory_writer.sv
// memory_writer: buffered client write port into a shared, arbitrated memory.
// Address/data pairs are queued in a small FIFO. The head entry is replayed as
// a memory write cycle once the arbiter grants the bus. The memory-side outputs
// float whenever grant is not held, so several masters can share the bus.
// Optional feature macro: MEMWRITER_BURST_EN. When it is defined, up to
// MAX_BURST words are written per grant; otherwise one word per grant.
//
// Handshakes:
//   client : a word is accepted on a rising clk edge where in_valid && in_ready.
//            in_ready is simply "FIFO not full"; a push offered while full is
//            dropped even if an entry leaves in the same cycle.
//   memory : mem_wr_enable is held high (PRE_WRITE) until mem_busy is seen
//            high; the cycle completes when mem_busy is then seen low. The
//            entry is popped only after that completion (POST_WRITE).
module memory_writer #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [ADDR_W-1:0]         in_addr,
   input  logic [DATA_W-1:0]         in_data,
   output logic                      in_ready,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      done,
   output logic                      arb_request,
   input  logic                      arb_grant,
   output logic [ADDR_W-1:0]         mem_wr_addr,
   output logic [DATA_W-1:0]         mem_wr_data,
   output logic                      mem_wr_enable,
   input  logic                      mem_busy,
   output logic [2:0]                dbg_state
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int BC_W  = $clog2(MAX_BURST + 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_GRANT = 3'd1,
      S_PRE_WRITE  = 3'd2,
      S_WRITE      = 3'd3,
      S_POST_WRITE = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_addr_mem [DEPTH];
   logic [DATA_W-1:0]   r_data_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [LVL_W-1:0]    r_level;
   logic [LVL_W-1:0]    w_level_next;
   logic [BC_W-1:0]     r_burst_cnt;
   logic [BC_W-1:0]     w_burst_next;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_continue;
   logic                w_request;
   logic                w_drive;

   assign w_full       = (r_level == LVL_W'(DEPTH));
   assign w_empty      = (r_level == '0);
   assign w_push       = in_valid && !w_full;
   assign w_pop        = (r_state == S_POST_WRITE);
   assign w_burst_next = r_burst_cnt + 1'b1;

   // Occupancy after this edge; a push and a pop together cancel out.
   always_comb begin
      w_level_next = r_level;
      if (w_push && !w_pop)
         w_level_next = r_level + 1'b1;
      else if (w_pop && !w_push)
         w_level_next = r_level - 1'b1;
   end

   // Continue a burst only if data remains after this pop and the per-grant
   // word count still leaves room.
`ifdef MEMWRITER_BURST_EN
   assign w_continue = (w_level_next != '0) && (w_burst_next < BC_W'(MAX_BURST));
`else
   assign w_continue = 1'b0;
`endif

   // FIFO storage; contents need no reset because level gates every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr_mem[r_wr_ptr] <= in_addr;
         r_data_mem[r_wr_ptr] <= in_data;
      end
   end

   // FIFO pointers and level; pointers wrap naturally since DEPTH is 2^PTR_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= w_level_next;
      end
   end

   // Words written under the current grant: cleared on a fresh request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_burst_cnt <= '0;
      else if (r_state != S_WAIT_GRANT && w_state_next == S_WAIT_GRANT)
         r_burst_cnt <= '0;
      else if (w_pop)
         r_burst_cnt <= w_burst_next;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // FSM next state and arbiter request. Losing grant mid-cycle sends the
   // same head entry back to WAIT_GRANT for a retry.
   always_comb begin
      w_state_next = r_state;
      w_request    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) w_state_next = S_WAIT_GRANT;
         end
         S_WAIT_GRANT: begin
            w_request = 1'b1;
            if (arb_grant) w_state_next = S_PRE_WRITE;
         end
         S_PRE_WRITE: begin
            w_request = 1'b1;
            if (!arb_grant)    w_state_next = S_WAIT_GRANT;
            else if (mem_busy) w_state_next = S_WRITE;
         end
         S_WRITE: begin
            w_request = 1'b1;
            if (!arb_grant)     w_state_next = S_WAIT_GRANT;
            else if (!mem_busy) w_state_next = S_POST_WRITE;
         end
         S_POST_WRITE: begin
            w_request    = w_continue;
            w_state_next = w_continue ? S_PRE_WRITE : S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_drive       = arb_grant && (r_state == S_PRE_WRITE || r_state == S_WRITE);
   assign mem_wr_addr   = w_drive ? r_addr_mem[r_rd_ptr] : {ADDR_W{1'bz}};
   assign mem_wr_data   = w_drive ? r_data_mem[r_rd_ptr] : {DATA_W{1'bz}};
   assign mem_wr_enable = arb_grant ? (r_state == S_PRE_WRITE) : 1'bz;

   assign in_ready    = !w_full;
   assign level       = r_level;
   assign done        = w_empty && (r_state == S_IDLE);
   assign arb_request = w_request;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_memory_writer.sv
// Directed bench for memory_writer: a cycle table for a single write, then
// hand-written sequences for full FIFO, grant loss, burst/non-burst request
// behaviour and asynchronous reset. Inputs change on falling edges; outputs
// are sampled 1 time unit after rising edges.
module tb_memory_writer;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_PRE = 3'd2, S_WR = 3'd3, S_POST = 3'd4;
  localparam logic [1:0] EN_0 = 2'd0, EN_1 = 2'd1, EN_Z = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_addr = '0;
  logic [15:0] in_data = '0;
  logic        arb_grant = 1'b0;
  logic        mem_busy = 1'b0;
  wire         in_ready;
  wire  [2:0]  level;
  wire         done;
  wire         arb_request;
  wire  [15:0] mem_wr_addr;
  wire  [15:0] mem_wr_data;
  wire         mem_wr_enable;
  wire  [2:0]  dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  memory_writer #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .MAX_BURST(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_ready(in_ready), .level(level), .done(done), .arb_request(arb_request),
    .arb_grant(arb_grant), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_enable(mem_wr_enable), .mem_busy(mem_busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic en_is_z, bus_is_z, en_hi;
  assign en_is_z  = (mem_wr_enable === 1'bz);
  assign bus_is_z = (mem_wr_addr === {16{1'bz}}) && (mem_wr_data === {16{1'bz}});
  assign en_hi    = !en_is_z && (mem_wr_enable === 1'b1);

  function automatic logic [1:0] en_code();
    return en_is_z ? EN_Z : {1'b0, mem_wr_enable};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // request-gap monitor: req-low cycles seen before each new enable pulse
  logic mon_on = 1'b0;
  logic prev_en = 1'b0;
  int   low_cnt = 0;
  int   gap_q[$];
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      if (en_hi && !prev_en) begin
        gap_q.push_back(low_cnt);
        low_cnt = 0;
      end
      if (arb_request == 1'b0) low_cnt++;
      prev_en = en_hi;
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; arb_grant = 1'b0; mem_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_addr = a; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Memory model for one write: waits for enable, checks the bus, gives a
  // one-cycle busy pulse, optionally pushes during POST_WRITE, checks level.
  task automatic serve(input logic [15:0] ea, input logic [15:0] ed, input logic pv,
                       input logic [15:0] pa, input logic [15:0] pd, input int el);
    int n = 0;
    while (!en_hi && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!en_hi) begin
      chk("serve_enable_timeout", 32'(n), 32'd40 + 32'd1);
      return;
    end
    chk("serve_addr", 32'(mem_wr_addr), 32'(ea));
    chk("serve_data", 32'(mem_wr_data), 32'(ed));
    @(negedge clk); mem_busy = 1'b1;
    @(posedge clk); #1;
    chk("serve_write_state", 32'(dbg_state), 32'(S_WR));
    @(negedge clk); mem_busy = 1'b0;
    @(posedge clk); #1;
    chk("serve_post_state", 32'(dbg_state), 32'(S_POST));
    @(negedge clk);
    if (pv) begin
      in_valid = 1'b1; in_addr = pa; in_data = pd;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("serve_level_after_pop", 32'(level), 32'(el));
  endtask

  typedef struct {
    logic       v;
    logic [15:0] a;
    logic [15:0] d;
    logic       g;
    logic       b;
    logic       rdy;
    logic [2:0] lvl;
    logic       dn;
    logic       req;
    logic [1:0] en;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // single write: grant 2 cycles after request, busy 1 cycle after enable for 2 cycles
    tbl[0] = '{1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, EN_Z, S_IDLE};
    tbl[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, EN_Z, S_WAIT};
    tbl[2] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, EN_Z, S_WAIT};
    tbl[3] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, EN_1, S_PRE};
    tbl[4] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, EN_1, S_PRE};
    tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, EN_0, S_WR};
    tbl[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, EN_0, S_WR};
    tbl[7] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, EN_0, S_POST};
    tbl[8] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, EN_0, S_IDLE};
    tbl[9] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, EN_Z, S_IDLE};

    // reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_arb_request", 32'(arb_request), 32'd0);
    chk("rst_bus_z", 32'(en_is_z && bus_is_z), 32'd1);

    // single write, table driven
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v; in_addr = tbl[i].a; in_data = tbl[i].d;
      arb_grant = tbl[i].g; mem_busy = tbl[i].b;
      @(posedge clk); #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("v%0d_arb_request", i), 32'(arb_request), 32'(tbl[i].req));
      chk($sformatf("v%0d_enable", i), 32'(en_code()), 32'(tbl[i].en));
      chk($sformatf("v%0d_state", i), 32'(dbg_state), 32'(tbl[i].st));
      if (tbl[i].en == EN_1) begin
        chk($sformatf("v%0d_addr", i), 32'(mem_wr_addr), 32'h0010);
        chk($sformatf("v%0d_data", i), 32'(mem_wr_data), 32'hBEEF);
      end
    end
    in_valid = 1'b0; arb_grant = 1'b0; mem_busy = 1'b0;

    // full FIFO: 5 pushes with grant low, 5th dropped; pointer wrap on drain
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(16'h0100 + 16'(i), 16'hA000 + 16'(i));
      chk($sformatf("full_level_%0d", i), 32'(level), (i < 4) ? 32'(i + 1) : 32'd4);
      chk($sformatf("full_in_ready_%0d", i), 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    chk("full_state_wait", 32'(dbg_state), 32'(S_WAIT));
    @(negedge clk); arb_grant = 1'b1;
    serve(16'h0100, 16'hA000, 1'b1, 16'h0BAD, 16'h0BAD, 3);  // push while full is dropped
    serve(16'h0101, 16'hA001, 1'b1, 16'h0200, 16'hB000, 3);  // push+pop keeps level
    serve(16'h0102, 16'hA002, 1'b0, 16'h0000, 16'h0000, 2);
    serve(16'h0103, 16'hA003, 1'b0, 16'h0000, 16'h0000, 1);
    serve(16'h0200, 16'hB000, 1'b0, 16'h0000, 16'h0000, 0);
    @(negedge clk); arb_grant = 1'b0;
    @(posedge clk); #1;
    chk("full_done", 32'(done), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd1);

    // grant loss during WRITE
    do_reset();
    push(16'h0500, 16'hD000);
    @(negedge clk); arb_grant = 1'b1;
    for (int n = 0; n < 20 && !en_hi; n++) begin
      @(posedge clk); #1;
    end
    chk("gl_first_enable", 32'(en_hi), 32'd1);
    @(negedge clk); mem_busy = 1'b1;
    @(posedge clk); #1;
    chk("gl_in_write", 32'(dbg_state), 32'(S_WR));
    @(negedge clk); arb_grant = 1'b0; mem_busy = 1'b0;
    #1;
    chk("gl_bus_z", 32'(en_is_z && bus_is_z), 32'd1);
    @(posedge clk); #1;
    chk("gl_state_wait", 32'(dbg_state), 32'(S_WAIT));
    chk("gl_level_kept", 32'(level), 32'd1);
    chk("gl_request", 32'(arb_request), 32'd1);
    @(negedge clk); arb_grant = 1'b1;
    @(posedge clk); #1;
    chk("gl_regrant_state", 32'(dbg_state), 32'(S_PRE));
    serve(16'h0500, 16'hD000, 1'b0, 16'h0000, 16'h0000, 0);
    @(negedge clk); arb_grant = 1'b0;

    // burst / non-burst request behaviour: 3 queued words, grant always high
    do_reset();
    for (int i = 0; i < 3; i++) push(16'h0400 + 16'(i), 16'hC000 + 16'(i));
    gap_q.delete();
    low_cnt = 0; prev_en = 1'b0; mon_on = 1'b1;
    @(negedge clk); arb_grant = 1'b1;
    serve(16'h0400, 16'hC000, 1'b0, 16'h0000, 16'h0000, 2);
    serve(16'h0401, 16'hC001, 1'b0, 16'h0000, 16'h0000, 1);
    serve(16'h0402, 16'hC002, 1'b0, 16'h0000, 16'h0000, 0);
    mon_on = 1'b0;
    chk("burst_write_count", 32'(gap_q.size()), 32'd3);
    if (gap_q.size() == 3) begin
`ifdef MEMWRITER_BURST_EN
      chk("burst_gap_w2_none", 32'(gap_q[1]), 32'd0);
      chk("burst_gap_w3_dropped", 32'(gap_q[2] >= 1), 32'd1);
`else
      chk("nonburst_gap_w2_dropped", 32'(gap_q[1] >= 1), 32'd1);
      chk("nonburst_gap_w3_dropped", 32'(gap_q[2] >= 1), 32'd1);
`endif
    end
    @(negedge clk); arb_grant = 1'b0;

    // asynchronous reset mid-WRITE with 3 entries queued
    do_reset();
    for (int i = 0; i < 3; i++) push(16'h0600 + 16'(i), 16'hE000 + 16'(i));
    @(negedge clk); arb_grant = 1'b1;
    for (int n = 0; n < 20 && !en_hi; n++) begin
      @(posedge clk); #1;
    end
    @(negedge clk); mem_busy = 1'b1;
    @(posedge clk); #1;
    chk("ar_in_write", 32'(dbg_state), 32'(S_WR));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_level", 32'(level), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_done", 32'(done), 32'd1);
    chk("ar_request", 32'(arb_request), 32'd0);
    chk("ar_enable_low", 32'(en_code()), 32'(EN_0));
    chk("ar_bus_z", 32'(bus_is_z), 32'd1);
    @(negedge clk); rst = 1'b0; mem_busy = 1'b0;
    begin
      int pulses = 0;
      for (int n = 0; n < 12; n++) begin
        @(posedge clk); #1;
        if (en_hi) pulses++;
      end
      chk("ar_no_enable_after", 32'(pulses), 32'd0);
    end
    arb_grant = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
